muldiv_sched: RTL

MULDIV_SCHED -- requirements
Module: muldiv_sched

---
 rtl/muldiv_sched_pkg.sv | 43 ++++
 rtl/muldiv_iter.sv | 49 ++++
 rtl/muldiv_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/muldiv_sched_pkg.sv
// muldiv_sched_pkg: funct3 encodings, iteration count, FSM states and operand helpers
// shared by muldiv_sched and its bench.
package muldiv_sched_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    localparam int ITER_N = 32;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        slot;
    } mop_t;

    function automatic logic sgn_a(input logic [2:0] op);
        return op == F_MULH || op == F_MULHSU || op == F_DIV || op == F_REM;
    endfunction

    function automatic logic sgn_b(input logic [2:0] op);
        return op == F_MULH || op == F_DIV || op == F_REM;
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? -v : v;
    endfunction

    // divide by zero and signed overflow resolve without touching the datapath
    function automatic logic fast_path(input mop_t m);
        return m.op[2] && (m.b == '0 || (!m.op[0] && m.a == 32'h80000000 && m.b == '1));
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: shift-add multiply / restoring divide on unsigned magnitudes.
// MULDIV_FAST_MUL_EN replaces the multiply step with one full-width product.
module muldiv_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        step_i,
    input  logic        div_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] acc_o
);
    logic [63:0] acc_q, acc_d, mul_nx, div_nx;
    logic [31:0] b_q, b_d, diff;
    logic        div_q, div_d, ge;

`ifdef MULDIV_FAST_MUL_EN
    assign mul_nx = {32'b0, acc_q[31:0]} * {32'b0, b_q};
`else
    logic [32:0] sum;
    assign sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_nx = {sum, acc_q[31:1]};
`endif

    // remainder lives in [63:32], quotient bits shift in at [0]
    assign ge     = acc_q[63:31] >= {1'b0, b_q};
    assign diff   = acc_q[62:31] - b_q;
    assign div_nx = ge ? {diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

    always_comb begin
        acc_d = start_i ? {32'b0, a_i} : step_i ? (div_q ? div_nx : mul_nx) : acc_q;
        b_d   = start_i ? b_i : b_q;
        div_d = start_i ? div_i : div_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: two-slot M-extension scheduler over one shared iterative datapath.
// MULDIV_FAST_MUL_EN selects a single-cycle registered multiplier for MUL*.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req0_i,
    input  logic            req1_i,
    input  logic [2:0]      op0_i,
    input  logic [2:0]      op1_i,
    input  logic [XLEN-1:0] a0_i,
    input  logic [XLEN-1:0] b0_i,
    input  logic [XLEN-1:0] a1_i,
    input  logic [XLEN-1:0] b1_i,
    input  logic [4:0]      rd0_i,
    input  logic [4:0]      rd1_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            slot_o,
    output logic            busy_o
);
    state_e      state_q, state_d;
    mop_t        cur_q, cur_d, pend_q, pend_d, src, in0, in1;
    logic        pend_v_q, pend_v_d, launch;
    logic [4:0]  cnt_q, cnt_d, last;
    logic [63:0] acc, prod;
    logic        neg_p, sdiv;
    logic [31:0] quo, rem, mul_res, div_res;

    assign in0 = {op0_i, a0_i, b0_i, rd0_i, 1'b0};
    assign in1 = {op1_i, a1_i, b1_i, rd1_i, 1'b1};

`ifdef MULDIV_FAST_MUL_EN
    assign last = cur_q.op[2] ? 5'(ITER_N - 1) : 5'd0;
`else
    assign last = 5'(ITER_N - 1);
`endif

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        cnt_d    = cnt_q;
        src      = pend_q;
        launch   = 1'b0;
        case (state_q)
            IDLE: if (req0_i || req1_i) begin
                launch   = 1'b1;
                src      = req0_i ? in0 : in1;
                pend_d   = in1;
                pend_v_d = req0_i && req1_i;
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == last) state_d = DONE;
            end
            DONE: begin
                state_d  = IDLE;
                launch   = pend_v_q;
                pend_v_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            cur_d   = src;
            cnt_d   = '0;
            state_d = fast_path(src) ? DONE : CALC;
        end
        if (flush_i) begin
            state_d  = IDLE;
            pend_v_d = 1'b0;
            launch   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            cnt_q    <= cnt_d;
        end
    end

    muldiv_iter u_iter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(launch),
        .step_i (state_q == CALC),
        .div_i  (src.op[2]),
        .a_i    (mag(src.a, sgn_a(src.op))),
        .b_i    (mag(src.b, sgn_b(src.op))),
        .acc_o  (acc)
    );

    // sign fix-up on the unsigned magnitude result
    always_comb begin
        sdiv    = ~cur_q.op[0];
        neg_p   = (sgn_a(cur_q.op) & cur_q.a[31]) ^ (sgn_b(cur_q.op) & cur_q.b[31]);
        prod    = neg_p ? -acc : acc;
        mul_res = cur_q.op == F_MUL ? prod[31:0] : prod[63:32];
        quo     = (sdiv && (cur_q.a[31] ^ cur_q.b[31])) ? -acc[31:0] : acc[31:0];
        rem     = (sdiv && cur_q.a[31]) ? -acc[63:32] : acc[63:32];
        div_res = cur_q.b == '0 ? (cur_q.op[1] ? cur_q.a : '1) :
                  fast_path(cur_q) ? (cur_q.op[1] ? '0 : 32'h80000000) :
                  cur_q.op[1] ? rem : quo;
    end

    assign result_o = state_q == DONE ? (cur_q.op[2] ? div_res : mul_res) : '0;
    assign done_o   = state_q == DONE && !flush_i;
    assign rd_o     = cur_q.rd;
    assign slot_o   = cur_q.slot;
    assign busy_o   = state_q != IDLE;
    assign stall_o  = (state_q == IDLE && (req0_i || req1_i)) || state_q == CALC ||
                      (state_q == DONE && pend_v_q);
endmodule
